v35_periph: RTL
===============

// Module: v35_periph
// PURPOSE
//  Parametrised on-chip peripheral block for the V35-class CPU wrapper, placed between the
//  v30_core bus and the external memory bus. Provides relocatable internal RAM and SFR
//  window, programmable external wait states (WTC), and NUM_EXI prioritised edge-triggered
//  external interrupt channels (EXICn) delivering a vectored irq/ack handshake to the core.
// PARAMETERS
//  IRAM_BYTES  256   implemented internal RAM bytes (1..256); window offsets >= IRAM_BYTES unmapped
//  NUM_EXI     3     external interrupt channels (1..8), EXICn at SFR offset 0x4C+n
//  VEC_BASE    8'h18 vector of channel 0; channel n -> VEC_BASE+n
//  CE_DIV      4     core ce = one pulse per CE_DIV ce pulses (power of 2, 2..16)
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   asynchronous active-low reset
//  ce           in   1   4x internal clock enable; all state advances only when ce=1
//  core_ce      out  1   divided enable for v30_core (1-clk pulse)
//  cpu_rd       in   1   core read strobe
//  cpu_wr       in   1   core write strobe
//  cpu_prefetch in   1   access is an opcode prefetch
//  cpu_be       in   2   byte enables
//  cpu_addr     in   20  byte address
//  cpu_dout     in   16  core write data
//  cpu_din      out  16  read data to core
//  cpu_ready    out  1   0 = stall core (wait state in progress)
//  mem_rd       out  1   external read strobe
//  mem_wr       out  1   external write strobe
//  mem_be       out  2   = cpu_be
//  mem_addr     out  20  = cpu_addr
//  mem_dout     out  16  = cpu_dout
//  mem_din      in   16  external read data
//  int_in       in   NUM_EXI  asynchronous external interrupt inputs
//  irq          out  1   interrupt request to core
//  irq_vec      out  8   vector of pending winner
//  irq_ack      in   1   core acknowledge, one ce-qualified pulse
// BEHAVIOUR
//  Reset: core_ce=0, cpu_ready=1, mem_rd=mem_wr=0, irq=0, irq_vec=VEC_BASE, cpu_din=0;
//   SFR IDB(0xFF)=0xFF, WTC(0xE8/E9)=0xFFFF, EXICn=0x47, other SFRs 0; IRAM not cleared.
//  Divider: 4-bit counter on ce; core_ce pulses on the ce where counter==CE_DIV-1, then wraps.
//  Decode: int_rq = ~cpu_prefetch & (addr[19:9]=={IDB,3'b111} | addr==20'hFFFFF);
//   addr[8]=1 -> SFR, 0 -> IRAM. mem_rd/mem_wr = cpu_rd/cpu_wr & ~int_rq & wait done.
//  Internal access: ce-qualified; byte lane0 at addr[7:0], lane1 at addr[7:0]+1 (8-bit wrap,
//   0xFF+1 -> 0x00). Write by be. Read data registered, valid on cpu_din next clk.
//   Unmapped IRAM reads 0xFF, writes dropped. Internal accesses: zero waits, cpu_ready=1.
//  Wait states: on first ce of an external rd/wr, load wcnt = WTC[2k+1:2k], k=addr[19:17];
//   cpu_ready=0 and mem strobes held 0 while wcnt!=0, decrement per core_ce; strobe issued
//   when wcnt==0, cpu_ready=1. States IDLE->WAIT->ACCESS->IDLE; access dropped mid-wait
//   (rd/wr low) returns to IDLE without strobing. WTC change affects next access only.
//  Interrupts: int_in double-flop synchronised, rising edge sets EXICn.IF (bit7).
//   EXICn: bit7 IF, bit6 MK (1=masked), bits2:0 PR (0 highest). CPU write updates all bits;
//   same-ce edge and CPU write: IF=1 (edge wins).
//  Arbitration (comb, registered to irq/irq_vec each ce): eligible = IF & ~MK; winner =
//   lowest PR, tie -> lowest n. irq=1 while any eligible and no ack in progress.
//  irq_ack: latch winner, clear its IF, irq=0 for that ce; re-evaluate next ce. Edge on same
//   channel coincident with ack -> IF stays 1 (request not lost). Ack with no eligible ignored.
//  reset_n low mid-access: all state to reset values immediately, strobes deasserted async.
// TESTING
//  1 Reset: reset_n=0 -> IDB=0xFF, read 0xFFFE8 returns 0xFFFF, EXIC0 reads 0x47, irq=0.
//  2 IRAM: IDB=0xFF, write word 0xA55A at 0xFFE10 be=11, read -> 0xA55A, mem_wr never 1;
//    prefetch at same addr -> mem_rd=1 (external).
//  3 Relocate: write IDB=0x80, write 0x80E20 internal; access 0xFFE20 goes external.
//  4 Waits: WTC=0x0003 (block0=3), external rd 0x01000 -> cpu_ready low 3 core_ce, then
//    mem_rd; block1 access (0x20000) with WTC[3:2]=0 -> zero waits.
//  5 Priority: EXIC0 PR=5, EXIC2 PR=1, both unmasked, pulse int_in[0],[2] -> irq=1,
//    irq_vec=VEC_BASE+2; ack -> EXIC2.IF=0, irq_vec=VEC_BASE+0; masked channel never wins.
//  6 Race: int_in[1] edge on same ce as irq_ack for ch1 -> EXIC1.IF stays 1, irq reasserts.

Source files
------------

// File: rtl/v35_periph.sv
// V35 on-chip peripherals: relocatable internal RAM / SFR window, WTC wait-state
// engine for external accesses, and prioritised edge-triggered external interrupts.
module v35_periph #(
    parameter int         IRAM_BYTES = 256,
    parameter int         NUM_EXI    = 3,
    parameter logic [7:0] VEC_BASE   = 8'h18,
    parameter int         CE_DIV     = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce,
    output logic               core_ce,
    input  logic               cpu_rd,
    input  logic               cpu_wr,
    input  logic               cpu_prefetch,
    input  logic [1:0]         cpu_be,
    input  logic [19:0]        cpu_addr,
    input  logic [15:0]        cpu_dout,
    output logic [15:0]        cpu_din,
    output logic               cpu_ready,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic [1:0]         mem_be,
    output logic [19:0]        mem_addr,
    output logic [15:0]        mem_dout,
    input  logic [15:0]        mem_din,
    input  logic [NUM_EXI-1:0] int_in,
    output logic               irq,
    output logic [7:0]         irq_vec,
    input  logic               irq_ack
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} wstate_t;

    localparam logic [3:0] DIV_LAST = 4'(CE_DIV - 1);
    localparam logic [8:0] IRAM_LIM = 9'(IRAM_BYTES);

    logic [3:0]  div_cnt;
    logic [7:0]  idb;
    logic [15:0] wtc;
    logic [15:0] din_q;
    logic [7:0]  iram [0:255];

    logic [NUM_EXI-1:0][7:0] exic;
    logic [NUM_EXI-1:0][7:0] exic_nxt;
    logic [NUM_EXI-1:0]      sync1, sync2, sync3, rise, elig;

    logic        int_rq, ext_req, is_sfr, int_wr, int_rd, we_lo, we_hi;
    logic [7:0]  off0, off1, rd_lo, rd_hi;
    logic [1:0]  wtc_field;
    logic        any_elig, ack_clr, wait_done;
    logic [2:0]  win_idx, best_pr;

    wstate_t     state, state_nxt;
    logic [1:0]  wcnt, wcnt_nxt;

    // Core clock enable divider
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            div_cnt <= 4'd0;
        else if (ce)
            div_cnt <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
    end

    assign core_ce = ce & (div_cnt == DIV_LAST);

    // Address decode; 0xFFFFF always reaches IDB so the window can be moved back
    assign int_rq    = ~cpu_prefetch & ((cpu_addr[19:9] == {idb, 3'b111}) | (cpu_addr == 20'hFFFFF));
    assign is_sfr    = cpu_addr[8];
    assign off0      = cpu_addr[7:0];
    assign off1      = off0 + 8'd1;
    assign ext_req   = (cpu_rd | cpu_wr) & ~int_rq;
    assign int_wr    = ce & cpu_wr & int_rq;
    assign int_rd    = ce & cpu_rd & int_rq;
    assign we_lo     = int_wr & is_sfr & cpu_be[0];
    assign we_hi     = int_wr & is_sfr & cpu_be[1];
    assign wtc_field = wtc[{cpu_addr[19:17], 1'b0} +: 2];

    function automatic logic mapped(input logic [7:0] off);
        return {1'b0, off} < IRAM_LIM;
    endfunction

    function automatic logic sfr_hit(input logic [7:0] t);
        return (we_lo && off0 == t) || (we_hi && off1 == t);
    endfunction

    function automatic logic [7:0] sfr_wdata(input logic [7:0] t);
        return (we_lo && off0 == t) ? cpu_dout[7:0] : cpu_dout[15:8];
    endfunction

    function automatic logic [7:0] sfr_byte(input logic [7:0] off);
        logic [7:0] v;
        v = 8'h00;
        if (off == 8'hFF) v = idb;
        if (off == 8'hE8) v = wtc[7:0];
        if (off == 8'hE9) v = wtc[15:8];
        for (int n = 0; n < NUM_EXI; n++)
            if (off == 8'(8'h4C + n)) v = exic[n];
        return v;
    endfunction

    function automatic logic [7:0] iram_byte(input logic [7:0] off);
        return mapped(off) ? iram[off] : 8'hFF;
    endfunction

    assign rd_lo = is_sfr ? sfr_byte(off0) : iram_byte(off0);
    assign rd_hi = is_sfr ? sfr_byte(off1) : iram_byte(off1);

    // IRAM contents survive reset
    always_ff @(posedge clk) begin
        if (int_wr && !is_sfr) begin
            if (cpu_be[0] && mapped(off0)) iram[off0] <= cpu_dout[7:0];
            if (cpu_be[1] && mapped(off1)) iram[off1] <= cpu_dout[15:8];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idb <= 8'hFF;
            wtc <= 16'hFFFF;
        end else begin
            if (sfr_hit(8'hFF)) idb       <= sfr_wdata(8'hFF);
            if (sfr_hit(8'hE8)) wtc[7:0]  <= sfr_wdata(8'hE8);
            if (sfr_hit(8'hE9)) wtc[15:8] <= sfr_wdata(8'hE9);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            din_q <= 16'h0000;
        else if (int_rd)
            din_q <= {rd_hi, rd_lo};
        else if (ce && mem_rd)
            din_q <= mem_din;
    end

    assign cpu_din = din_q;

    // Wait-state FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            wcnt  <= 2'd0;
        end else if (ce) begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Wait-state FSM: next state
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            S_IDLE: begin
                if (ext_req) begin
                    wcnt_nxt  = wtc_field;
                    state_nxt = (wtc_field == 2'd0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!ext_req) begin
                    state_nxt = S_IDLE;
                    wcnt_nxt  = 2'd0;
                end else if (core_ce) begin
                    wcnt_nxt = wcnt - 2'd1;
                    if (wcnt == 2'd1) state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!ext_req || core_ce) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Wait-state FSM: outputs; strobes and ready forced inactive while in reset
    always_comb begin
        wait_done = (state == S_ACCESS) || (state == S_IDLE && wtc_field == 2'd0);
        mem_rd    = reset_n & cpu_rd & ~int_rq & wait_done;
        mem_wr    = reset_n & cpu_wr & ~int_rq & wait_done;
        cpu_ready = ~reset_n | ~ext_req | wait_done;
    end

    assign mem_be   = cpu_be;
    assign mem_addr = cpu_addr;
    assign mem_dout = cpu_dout;

    // Arbitration: lowest PR wins, ties go to the lowest channel
    always_comb begin
        any_elig = 1'b0;
        win_idx  = 3'd0;
        best_pr  = 3'd7;
        for (int n = 0; n < NUM_EXI; n++) begin
            elig[n] = exic[n][7] & ~exic[n][6];
            if (elig[n] && (!any_elig || exic[n][2:0] < best_pr)) begin
                any_elig = 1'b1;
                win_idx  = 3'(n);
                best_pr  = exic[n][2:0];
            end
        end
    end

    assign rise    = sync2 & ~sync3;
    assign ack_clr = ce & irq_ack & any_elig;

    // A synchronised edge always leaves IF set, even against a write or an ack
    always_comb begin
        for (int n = 0; n < NUM_EXI; n++) begin
            exic_nxt[n] = exic[n];
            if (sfr_hit(8'(8'h4C + n)))
                exic_nxt[n] = sfr_wdata(8'(8'h4C + n));
            else if (ack_clr && win_idx == 3'(n))
                exic_nxt[n][7] = 1'b0;
            if (rise[n])
                exic_nxt[n][7] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= '0;
            sync2   <= '0;
            sync3   <= '0;
            exic    <= {NUM_EXI{8'h47}};
            irq     <= 1'b0;
            irq_vec <= VEC_BASE;
        end else if (ce) begin
            sync1   <= int_in;
            sync2   <= sync1;
            sync3   <= sync2;
            exic    <= exic_nxt;
            irq     <= any_elig & ~irq_ack;
            irq_vec <= VEC_BASE + {5'b0, win_idx};
        end
    end

endmodule
